// File: rtl/mesh_pkg.sv
// Shared sizes, payload types and FSM state encoding for the PE-mesh operand skew stage.
package mesh_pkg;

  localparam int MESH_N  = 4;
  localparam int A_W     = 8;
  localparam int B_W     = 20;
  localparam int SHIFT_W = 5;
  localparam int ID_W    = 3;
  localparam int CNT_W   = (MESH_N > 1) ? $clog2(MESH_N) : 1;

  typedef struct packed {
    logic               dataflow;
    logic               propagate;
    logic [SHIFT_W-1:0] shift;
  } pe_ctrl_t;

  // Field order is relied on when a column beat is packed from input slices.
  typedef struct packed {
    logic [B_W-1:0]  b;
    logic [B_W-1:0]  d;
    pe_ctrl_t        ctrl;
    logic [ID_W-1:0] id;
    logic            last;
  } col_beat_t;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} skew_state_e;

endpackage

// File: rtl/mesh_operand_skew_if.sv
// Operand intake handshake plus the skewed row/column outputs of the mesh skew stage.
interface mesh_operand_skew_if;
  import mesh_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [MESH_N*A_W-1:0]     in_a;
  logic [MESH_N*B_W-1:0]     in_b;
  logic [MESH_N*B_W-1:0]     in_d;
  logic                      in_ctrl_dataflow;
  logic                      in_ctrl_propagate;
  logic [SHIFT_W-1:0]        in_ctrl_shift;
  logic [ID_W-1:0]           in_id;
  logic                      in_last;

  logic [MESH_N-1:0]         out_a_valid;
  logic [MESH_N*A_W-1:0]     out_a;
  logic [MESH_N-1:0]         out_col_valid;
  logic [MESH_N*B_W-1:0]     out_b;
  logic [MESH_N*B_W-1:0]     out_d;
  logic [MESH_N-1:0]         out_ctrl_dataflow;
  logic [MESH_N-1:0]         out_ctrl_propagate;
  logic [MESH_N*SHIFT_W-1:0] out_ctrl_shift;
  logic [MESH_N*ID_W-1:0]    out_id;
  logic [MESH_N-1:0]         out_last;
  logic                      busy;
  logic                      done;

  modport master (
    output in_valid, in_a, in_b, in_d, in_ctrl_dataflow, in_ctrl_propagate,
           in_ctrl_shift, in_id, in_last,
    input  in_ready, out_a_valid, out_a, out_col_valid, out_b, out_d,
           out_ctrl_dataflow, out_ctrl_propagate, out_ctrl_shift, out_id,
           out_last, busy, done
  );

  modport slave (
    input  in_valid, in_a, in_b, in_d, in_ctrl_dataflow, in_ctrl_propagate,
           in_ctrl_shift, in_id, in_last,
    output in_ready, out_a_valid, out_a, out_col_valid, out_b, out_d,
           out_ctrl_dataflow, out_ctrl_propagate, out_ctrl_shift, out_id,
           out_last, busy, done
  );

endinterface

// File: rtl/skew_delay_line.sv
// DEPTH-stage register chain carrying a valid bit; data stages only load behind a valid beat.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]     data_q [DEPTH];

  // Bubbles travel as valid=0 while the data stages keep their old contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) data_q[0] <= in_data;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) data_q[k] <= data_q[k-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/mesh_operand_skew.sv
// Skews one operand beat per cycle into a diagonal wavefront (lane i delayed i+1 cycles)
// and blocks intake while a finished tile drains out of the deepest lane.
module mesh_operand_skew
  import mesh_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  mesh_operand_skew_if.slave bus
);

  localparam int COL_W = $bits(col_beat_t);

  skew_state_e      state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             ready_c, busy_c;

  logic [MESH_N-1:0] row_valid, col_valid;
  logic [A_W-1:0]    row_data [MESH_N];
  col_beat_t         col_in   [MESH_N];
  col_beat_t         col_out  [MESH_N];

  assign accept = bus.in_valid & ready_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (accept && bus.in_last) cnt <= CNT_W'(MESH_N - 1);
      else if (state == DRAIN && cnt != '0) cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = bus.in_last ? DRAIN : STREAM;
      STREAM:  if (accept && bus.in_last) state_next = DRAIN;
      DRAIN:   if (cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_c = (state != DRAIN);
    busy_c  = (state != IDLE);
  end

  assign bus.in_ready = ready_c;
  assign bus.busy     = busy_c;
  assign bus.done     = col_valid[MESH_N-1] & col_out[MESH_N-1].last;

  for (genvar i = 0; i < MESH_N; i++) begin : g_lane
    assign col_in[i] = {bus.in_b[i*B_W +: B_W], bus.in_d[i*B_W +: B_W],
                        bus.in_ctrl_dataflow, bus.in_ctrl_propagate,
                        bus.in_ctrl_shift, bus.in_id, bus.in_last};

    skew_delay_line #(.DEPTH(i + 1), .W(A_W)) u_row (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (accept),
      .in_data   (bus.in_a[i*A_W +: A_W]),
      .out_valid (row_valid[i]),
      .out_data  (row_data[i])
    );

    skew_delay_line #(.DEPTH(i + 1), .W(COL_W)) u_col (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (accept),
      .in_data   (col_in[i]),
      .out_valid (col_valid[i]),
      .out_data  (col_out[i])
    );

    assign bus.out_a[i*A_W +: A_W]                = row_data[i];
    assign bus.out_b[i*B_W +: B_W]                = col_out[i].b;
    assign bus.out_d[i*B_W +: B_W]                = col_out[i].d;
    assign bus.out_ctrl_dataflow[i]               = col_out[i].ctrl.dataflow;
    assign bus.out_ctrl_propagate[i]              = col_out[i].ctrl.propagate;
    assign bus.out_ctrl_shift[i*SHIFT_W +: SHIFT_W] = col_out[i].ctrl.shift;
    assign bus.out_id[i*ID_W +: ID_W]             = col_out[i].id;
    assign bus.out_last[i]                        = col_out[i].last;
  end

  assign bus.out_a_valid   = row_valid;
  assign bus.out_col_valid = col_valid;

endmodule

// File: tb/tb_mesh_operand_skew.sv
// Directed bench for mesh_operand_skew: per-lane scoreboard queues tagged with the edge
// at which each beat must emerge, plus an independent intake/drain model.
module tb_mesh_operand_skew;
  import mesh_pkg::*;

  localparam int N = MESH_N;

  typedef struct {
    int                 due;
    logic [A_W-1:0]     a;
    logic [B_W-1:0]     b;
    logic [B_W-1:0]     d;
    logic               df;
    logic               pr;
    logic [SHIFT_W-1:0] sh;
    logic [ID_W-1:0]    id;
    logic               last;
  } exp_t;

  exp_t lane_q [N][$];

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  int   drain_left = 0;
  bit   in_tile = 1'b0;

  mesh_operand_skew_if bus ();

  mesh_operand_skew dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [N*A_W-1:0] rand_a();
    return N*A_W'($urandom());
  endfunction

  function automatic logic [N*B_W-1:0] rand_b();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[N*B_W-1:0];
  endfunction

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every lane against the scoreboard for the edge just taken.
  task automatic checkOutput(input int e);
    logic ev;
    logic exp_done;
    exp_t ent;
    exp_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      ev = (lane_q[i].size() > 0) && (lane_q[i][0].due == e);
      checkVal($sformatf("lane%0d_row_valid@%0d", i, e), 128'(bus.out_a_valid[i]), 128'(ev));
      checkVal($sformatf("lane%0d_col_valid@%0d", i, e), 128'(bus.out_col_valid[i]), 128'(ev));
      if (ev) begin
        ent = lane_q[i].pop_front();
        checkVal($sformatf("lane%0d_row_data@%0d", i, e), 128'(bus.out_a[i*A_W +: A_W]), 128'(ent.a));
        checkVal($sformatf("lane%0d_col_data@%0d", i, e),
                 128'({bus.out_b[i*B_W +: B_W], bus.out_d[i*B_W +: B_W],
                       bus.out_ctrl_dataflow[i], bus.out_ctrl_propagate[i],
                       bus.out_ctrl_shift[i*SHIFT_W +: SHIFT_W],
                       bus.out_id[i*ID_W +: ID_W], bus.out_last[i]}),
                 128'({ent.b, ent.d, ent.df, ent.pr, ent.sh, ent.id, ent.last}));
        if (i == N-1) exp_done = ent.last;
      end
    end
    checkVal($sformatf("done@%0d", e), 128'(bus.done), 128'(exp_done));
    checkVal($sformatf("in_ready@%0d", e), 128'(bus.in_ready), 128'(drain_left == 0));
    checkVal($sformatf("busy@%0d", e), 128'(bus.busy), 128'(in_tile || drain_left > 0));
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, "_valids"}, 128'({bus.out_a_valid, bus.out_col_valid, bus.done}), 128'(0));
    checkVal({tag, "_row"}, 128'(bus.out_a), 128'(0));
    checkVal({tag, "_col"}, 128'({bus.out_b, bus.out_d}), 128'(0));
    checkVal({tag, "_ctrl"}, 128'({bus.out_ctrl_dataflow, bus.out_ctrl_propagate,
                                   bus.out_ctrl_shift, bus.out_id, bus.out_last}), 128'(0));
    checkVal({tag, "_ready"}, 128'(bus.in_ready), 128'(1));
    checkVal({tag, "_busy"}, 128'(bus.busy), 128'(0));
  endtask

  // Drive one cycle of input, record expected lane outputs if the model accepts, then check.
  task automatic applyStimulus(input logic v, input logic [N*A_W-1:0] a,
                               input logic [N*B_W-1:0] b, input logic [N*B_W-1:0] d,
                               input logic df, input logic pr,
                               input logic [SHIFT_W-1:0] sh, input logic [ID_W-1:0] id,
                               input logic last, output bit acc);
    int   e;
    exp_t ent;
    bus.in_valid          = v;
    bus.in_a              = a;
    bus.in_b              = b;
    bus.in_d              = d;
    bus.in_ctrl_dataflow  = df;
    bus.in_ctrl_propagate = pr;
    bus.in_ctrl_shift     = sh;
    bus.in_id             = id;
    bus.in_last           = last;
    acc = v && (drain_left == 0);
    e = edge_cnt;
    if (acc) begin
      for (int i = 0; i < N; i++) begin
        ent.due  = e + i;
        ent.a    = a[i*A_W +: A_W];
        ent.b    = b[i*B_W +: B_W];
        ent.d    = d[i*B_W +: B_W];
        ent.df   = df;
        ent.pr   = pr;
        ent.sh   = sh;
        ent.id   = id;
        ent.last = last;
        lane_q[i].push_back(ent);
      end
    end
    @(posedge clock);
    edge_cnt++;
    if (drain_left > 0) drain_left--;
    else if (acc) begin
      if (last) begin
        drain_left = N;
        in_tile = 1'b0;
      end else in_tile = 1'b1;
    end
    #1;
    checkOutput(e);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++)
      applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, acc);
  endtask

  initial begin
    bit acc;
    int left;
    logic [N*B_W-1:0] b;
    logic [3:0] gap_v;

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_d = '0;
    bus.in_ctrl_dataflow = 1'b0; bus.in_ctrl_propagate = 1'b0;
    bus.in_ctrl_shift = '0; bus.in_id = '0; bus.in_last = 1'b0;

    @(posedge clock); #1;
    checkReset("reset");
    reset = 1'b0;

    $display("[TB] single beat tile");
    applyStimulus(1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, rand_b(), rand_b(), 1'b0, 1'b1, 5'd3, 3'd1, 1'b1, acc);
    idle(6);

    $display("[TB] eight beat tile");
    for (int k = 0; k < 8; k++) begin
      b = rand_b();
      b[B_W-1:0] = B_W'(k);
      applyStimulus(1'b1, rand_a(), b, rand_b(), 1'b1, 1'b0, 5'd2, 3'd2, k == 7, acc);
    end
    idle(6);

    $display("[TB] beats with gaps");
    gap_v = 4'b1101;
    for (int k = 0; k < 4; k++)
      applyStimulus(gap_v[k], rand_a(), rand_b(), rand_b(), 1'b0, 1'b0, 5'd4, 3'd3, 1'b0, acc);
    applyStimulus(1'b1, rand_a(), rand_b(), rand_b(), 1'b0, 1'b0, 5'd4, 3'd3, 1'b1, acc);
    idle(6);

    $display("[TB] control sweep");
    for (int k = 0; k < 6; k++)
      applyStimulus(1'b1, rand_a(), rand_b(), rand_b(), 1'b1, k[0], 5'h1F, 3'h7, k == 5, acc);
    idle(6);

    $display("[TB] reset during drain");
    applyStimulus(1'b1, rand_a(), rand_b(), rand_b(), 1'b0, 1'b1, 5'd9, 3'd4, 1'b0, acc);
    applyStimulus(1'b1, rand_a(), rand_b(), rand_b(), 1'b0, 1'b1, 5'd9, 3'd4, 1'b1, acc);
    idle(1);
    reset = 1'b1;
    #1;
    checkReset("mid_drain_reset");
    for (int i = 0; i < N; i++) lane_q[i].delete();
    drain_left = 0;
    in_tile = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    idle(6);

    $display("[TB] back to back tiles");
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 3 - t; k++) begin
        b = rand_b();
        left = 0;
        do begin
          applyStimulus(1'b1, {8'(t), 8'(k), 8'hA5, 8'(k)}, b, rand_b(), t[0], k[0],
                        5'(k), 3'(t + 5), k == 2 - t, acc);
          left++;
        end while (!acc && left < 3 * N);
        checkVal($sformatf("b2b_accept_t%0d_k%0d", t, k), 128'(acc), 128'(1));
      end
    end
    idle(6);

    left = 0;
    for (int i = 0; i < N; i++) left += lane_q[i].size();
    checkVal("scoreboard_empty", 128'(left), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
